// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: button conditioning (sync, debounce, press
// detect), a four-state run/pause/lap FSM, the 1 Hz tick prescaler and the lap-hold display mux.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TICK_DIV        = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_lc,
    input  logic [15:0] time_bcd,
    output logic        tick,
    output logic        clear,
    output logic        run,
    output logic        lap_active,
    output logic [1:0]  state,
    output logic [15:0] disp_bcd
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    localparam int unsigned       CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]       PRE_LAST = 32'(TICK_DIV - 1);

    // Button lanes: bit 0 is start/stop, bit 1 is lap/clear.
    logic [1:0]       raw;
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       deb;
    logic [1:0]       deb_d;
    logic [1:0]       press;
    logic [CNT_W-1:0] deb_cnt [2];

    state_t      state_q;
    state_t      state_n;
    logic        clear_q;
    logic        clear_n;
    logic        latch_n;
    logic [15:0] lap_reg;
    logic [31:0] presc;

    assign raw = {btn_lc, btn_ss};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    deb[i]     <= sync_b[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = deb & ~deb_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_n = state_q;
        clear_n = 1'b0;
        latch_n = 1'b0;
        if (press[0]) begin
            case (state_q)
                IDLE:    state_n = RUNNING;
                RUNNING: state_n = PAUSED;
                PAUSED:  state_n = RUNNING;
                LAP:     state_n = PAUSED;
                default: state_n = IDLE;
            endcase
        end else if (press[1]) begin
            case (state_q)
                IDLE: begin
                    clear_n = 1'b1;
                end
                RUNNING: begin
                    state_n = LAP;
                    latch_n = 1'b1;
                end
                PAUSED: begin
                    state_n = IDLE;
                    clear_n = 1'b1;
                end
                LAP:     state_n = RUNNING;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            clear_q <= 1'b0;
            lap_reg <= '0;
        end else begin
            state_q <= state_n;
            clear_q <= clear_n;
            if (latch_n) begin
                lap_reg <= time_bcd;
            end
        end
    end

    // Prescaler holds while paused so the fractional second survives a resume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (clear_n) begin
            presc <= '0;
        end else if (run) begin
            presc <= (presc == PRE_LAST) ? '0 : presc + 32'd1;
        end
    end

    assign run        = (state_q == RUNNING) || (state_q == LAP);
    assign lap_active = (state_q == LAP);
    assign tick       = run && (presc == PRE_LAST);
    assign clear      = clear_q;
    assign state      = state_q;
    assign disp_bcd   = lap_active ? lap_reg : time_bcd;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control front end for the stopwatch BCD counter datapath. Takes two raw pushbuttons, start/stop and lap/clear, then synchronizes and debounces them and edge-detects presses. A four-state FSM uses those presses to sequence the datapath: it generates the 1 Hz count-enable tick, a synchronous clear pulse and a lap-hold display mux. The block sits between board I/O and the BCD counter chain, which advances one second per `tick` and zeroes on `clear`.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles (post-sync) before a button level is accepted; must be ≥ 1.
- `TICK_DIV`, default 100_000_000: clock cycles per `tick`; must be ≥ 2.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_ss`  in  1  raw start/stop button, active-high, asynchronous to `clk`.
- `btn_lc`  in  1  raw lap/clear button, active-high, asynchronous to `clk`.
- `time_bcd`  in  16  live datapath time {min_tens, min_ones, sec_tens, sec_ones}, 4-bit BCD each.
- `tick`  out  1  one-cycle count enable to datapath.
- `clear`  out  1  one-cycle synchronous clear to datapath.
- `run`  out  1  high in RUNNING or LAP.
- `lap_active`  out  1  high in LAP.
- `state`  out  2  IDLE=0, RUNNING=1, PAUSED=2, LAP=3.
- `disp_bcd`  out  16  display value: `lap_reg` in LAP, else `time_bcd`.

## Operation
- Per button: 2-flop synchronizer → debouncer → rising-edge detector.
  - The debouncer counter increments while the sync output differs from the debounced level and resets to 0 when they match.
  - On a cycle where counter == DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the sync value and the counter returns to 0.
  - The press pulse equals debounced & ~debounced_delayed; it is one cycle wide. Release produces no event.
- FSM, evaluated on press pulses (`ss` = start/stop, `lc` = lap/clear):
  - IDLE: ss → RUNNING. lc → stay IDLE and pulse `clear`.
  - RUNNING: ss → PAUSED. lc → LAP and latch `lap_reg <= time_bcd`.
  - LAP: ss → PAUSED, releasing the hold. lc → RUNNING, releasing the hold.
  - PAUSED: ss → RUNNING. lc → IDLE and pulse `clear`.
  - If ss and lc pulse in the same cycle, ss wins and lc is dropped, with no clear and no latch.
- Prescaler, 32-bit:
  - While `run` is high, it counts 0..TICK_DIV-1 and wraps to 0.
  - It holds its value in PAUSED, so the fractional second is kept across a pause/resume.
  - It is zeroed at the edge that asserts `clear`.
- `tick` = run & (prescaler == TICK_DIV-1), decoded from registers.
- `clear` is a register, high for exactly the one cycle after the transition edge that requests it.
- The datapath keeps counting in LAP; only `disp_bcd` is frozen.

## Timing
- Reset (rst=0) values:
  - `state` = IDLE; `tick`, `clear`, `run`, `lap_active` = 0.
  - `lap_reg`, prescaler, synchronizers, debounced levels and debounce counters all = 0.
  - `disp_bcd` = `time_bcd`.
- Reset assert takes effect immediately (asynchronous). Deassert is released to the FSM on the next clock edge.
- Press latency: let edge 1 be the first edge that samples a raw button high, held stable.
  - Debounced level rises at edge DEBOUNCE_CYCLES+2.
  - `state` and `lap_reg` update, and `clear` asserts, at edge DEBOUNCE_CYCLES+3.
- A glitch shorter than DEBOUNCE_CYCLES sync cycles causes no event. The counter restarts when the levels match again.
- First tick: with RUNNING entered at edge E and prescaler = 0, `tick` is high in the cycle after edge E+TICK_DIV-1. After that it repeats every TICK_DIV cycles while running.
- RUNNING→LAP→RUNNING leaves the prescaler phase undisturbed; no tick is lost or duplicated.
- Button held through reset deassert: the debounced level restarts at 0, so the held button yields one press DEBOUNCE_CYCLES+3 edges after deassert. This is intended.
- Reset mid-debounce or mid-LAP: all state is discarded and no `clear` pulse is generated.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TICK_DIV=10.
- Reset, then hold `btn_ss` high from edge 1 → `state` 0→1 at edge 7, `run`=1. `tick` is first high 10 cycles later and every 10 cycles after that.
- 3-cycle `btn_ss` glitch in IDLE → no state change, `clear` stays 0, debounce counter back to 0.
- Run to prescaler=6, press ss, wait 50 cycles, press ss → prescaler holds 6 through PAUSED. The next tick arrives 3 cycles after re-entering RUNNING.
- In RUNNING with time_bcd=16'h0123, press lc → state=3, `disp_bcd` stays 16'h0123 while `time_bcd` advances. A second lc returns to state=1 and `disp_bcd` = live value.
- In PAUSED, press lc → state=0, `clear` high for exactly 1 cycle, prescaler = 0. In IDLE, a further lc → another 1-cycle `clear`, state stays 0.
- Raise `btn_ss` and `btn_lc` on the same edge in RUNNING → state=2 (PAUSED), no LAP entry, `lap_reg` unchanged. Asserting rst=0 mid-LAP → all outputs at reset values immediately.
